window_scan_ctrl: RTL and testbench

// Sequencer for the 3x3 Sobel window buffer. Walks the window centre over the image in serpentine order.
// Per move: issues the buffer shift, fetches only the new pixels from image memory, and feeds them into the buffer.

---
 rtl/sobel_pkg.sv | 52 +++++
 rtl/scan_pos_ctr.sv | 73 +++++++
 rtl/window_scan_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_window_scan_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window sequencer.
// Contents:
//   shift_dir_t  - window buffer shift command (load / right / left / down)
//   scan_state_t - sequencer FSM states
//   reads_for_dir - number of pixel fetches a given move needs
//   load_offset   - {row_off, col_off} of the idx-th pixel of a full 3x3 load
package sobel_pkg;

  typedef enum logic [1:0] {
    DIR_LOAD  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } shift_dir_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRO        = 3'd1,
    ST_SHIFT_WAIT = 3'd2,
    ST_FETCH      = 3'd3,
    ST_PRESENT    = 3'd4,
    ST_FIN        = 3'd5
  } scan_state_t;

  localparam logic [3:0] LOAD_READS = 4'd9;
  localparam logic [3:0] MOVE_READS = 4'd3;

  // A full load brings in the whole 3x3 window; any single-step move only
  // brings in the one new row or column of three pixels.
  function automatic logic [3:0] reads_for_dir(input shift_dir_t dir);
    return (dir == DIR_LOAD) ? LOAD_READS : MOVE_READS;
  endfunction

  // Row-major walk over the 3x3 block; returns {row_off, col_off}, each 0..2
  // relative to the window's top-left pixel.
  function automatic logic [3:0] load_offset(input logic [3:0] idx);
    logic [3:0] off;
    case (idx)
      4'd0:    off = {2'd0, 2'd0};
      4'd1:    off = {2'd0, 2'd1};
      4'd2:    off = {2'd0, 2'd2};
      4'd3:    off = {2'd1, 2'd0};
      4'd4:    off = {2'd1, 2'd1};
      4'd5:    off = {2'd1, 2'd2};
      4'd6:    off = {2'd2, 2'd0};
      4'd7:    off = {2'd2, 2'd1};
      default: off = {2'd2, 2'd2};
    endcase
    return off;
  endfunction

endpackage

// File: rtl/scan_pos_ctr.sv
// Window-centre position tracker for the serpentine scan.
// Holds the centre column/row and the parity of the current row pass
// (even passes run left-to-right, odd passes right-to-left) and derives the
// next move and whether the current window is the final one of the frame.
// Ports:
//   clk, n_rst - clock, asynchronous active-low reset
//   init       - return to the first centre (1,1), even pass
//   step       - apply next_dir to the position
//   col, row   - current centre coordinates
//   next_dir   - move that follows the current window
//   last_win   - current window is the last of the frame
module scan_pos_ctr
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              init,
  input  logic              step,
  output logic [ADDR_W-1:0] col,
  output logic [ADDR_W-1:0] row,
  output shift_dir_t        next_dir,
  output logic              last_win
);

  localparam logic [ADDR_W-1:0] FIRST    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 2);

  logic odd_pass;

  // Position register. A downward step ends a row pass, so it also flips
  // the pass direction for the next row.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      col      <= FIRST;
      row      <= FIRST;
      odd_pass <= 1'b0;
    end else if (init) begin
      col      <= FIRST;
      row      <= FIRST;
      odd_pass <= 1'b0;
    end else if (step) begin
      case (next_dir)
        DIR_RIGHT: col <= col + FIRST;
        DIR_LEFT:  col <= col - FIRST;
        DIR_DOWN: begin
          row      <= row + FIRST;
          odd_pass <= ~odd_pass;
        end
        default: ;
      endcase
    end
  end

  // Keep moving along the current pass until the row edge, then drop a row.
  always_comb begin
    next_dir = DIR_DOWN;
    if (!odd_pass && (col < COL_LAST)) begin
      next_dir = DIR_RIGHT;
    end else if (odd_pass && (col > FIRST)) begin
      next_dir = DIR_LEFT;
    end
  end

  // The frame ends at the far edge of the bottom row pass.
  assign last_win = (row == ROW_LAST) &&
                    (odd_pass ? (col == FIRST) : (col == COL_LAST));

endmodule

// File: rtl/window_scan_ctrl.sv
// Sequencer for the 3x3 Sobel window buffer.
// Walks the window centre over the image in serpentine order. For each move
// it commands the buffer shift, fetches only the newly exposed pixels from
// image memory (one read outstanding at a time), then presents the finished
// window to the Sobel core and waits for its acknowledge.
// Ports:
//   clk, n_rst      - clock, asynchronous active-low reset
//   start           - begin one frame scan (ignored unless idle)
//   busy / done     - frame in progress / one-cycle end-of-frame pulse
//   mem_rd_req      - read request, held until mem_rd_valid
//   mem_rd_addr     - pixel address row*IMG_W+col
//   mem_rd_valid    - read data delivered to the buffer this cycle
//   wb_start_shift  - one-cycle shift command to the window buffer
//   wb_start_read   - one-cycle buffer write strobe, follows mem_rd_valid
//   wb_shift_direc  - 00 load, 01 right, 10 left, 11 down
//   wb_shift_done   - buffer finished its shift
//   win_valid       - window complete, held until win_ack
//   win_ack         - Sobel core consumed the window
//   win_center      - address of the current window centre
module window_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_valid,
  output logic              wb_start_shift,
  output logic              wb_start_read,
  output logic [1:0]        wb_shift_direc,
  input  logic              wb_shift_done,
  output logic              win_valid,
  input  logic              win_ack,
  output logic [ADDR_W-1:0] win_center
);

  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] IMG_W_AW = ADDR_W'(IMG_W);

  scan_state_t       state;
  scan_state_t       state_nxt;
  shift_dir_t        dir;
  shift_dir_t        next_dir;
  logic [3:0]        rd_cnt;
  logic [3:0]        load_off;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] fetch_row;
  logic [ADDR_W-1:0] fetch_col;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] center_addr;
  logic              last_win;
  logic              last_read;
  logic              accept_start;
  logic              win_taken;
  logic              rd_taken;

  assign accept_start = (state == ST_IDLE) && start;
  assign win_taken    = (state == ST_PRESENT) && win_ack;
  assign rd_taken     = (state == ST_FETCH) && mem_rd_valid;
  assign last_read    = (rd_cnt == (reads_for_dir(dir) - 4'd1));

  scan_pos_ctr #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_pos (
    .clk     (clk),
    .n_rst   (n_rst),
    .init    (accept_start),
    .step    (win_taken && !last_win),
    .col     (col),
    .row     (row),
    .next_dir(next_dir),
    .last_win(last_win)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A full load has nothing to shift out of the buffer,
  // so it does not wait for the shift acknowledge.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:       if (start) state_nxt = ST_PRO;
      ST_PRO:        state_nxt = ST_SHIFT_WAIT;
      ST_SHIFT_WAIT: if ((dir == DIR_LOAD) || wb_shift_done) state_nxt = ST_FETCH;
      ST_FETCH:      if (mem_rd_valid && last_read) state_nxt = ST_PRESENT;
      ST_PRESENT:    if (win_ack) state_nxt = last_win ? ST_FIN : ST_PRO;
      ST_FIN:        state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end

  // Output decode. Addresses are forced to zero outside the states where
  // they are meaningful so idle outputs are all zero.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    mem_rd_req     = 1'b0;
    mem_rd_addr    = '0;
    wb_start_shift = 1'b0;
    wb_start_read  = 1'b0;
    wb_shift_direc = dir;
    win_valid      = 1'b0;
    win_center     = '0;
    case (state)
      ST_PRO: begin
        busy           = 1'b1;
        wb_start_shift = 1'b1;
      end
      ST_SHIFT_WAIT: busy = 1'b1;
      ST_FETCH: begin
        busy          = 1'b1;
        mem_rd_req    = 1'b1;
        mem_rd_addr   = fetch_addr;
        wb_start_read = mem_rd_valid;
      end
      ST_PRESENT: begin
        busy       = 1'b1;
        win_valid  = 1'b1;
        win_center = center_addr;
      end
      ST_FIN: done = 1'b1;
      default: ;
    endcase
  end

  // Move direction and fetch counter. The direction is latched once per move
  // so the buffer sees a stable command for the whole fetch.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dir    <= DIR_LOAD;
      rd_cnt <= '0;
    end else begin
      if (accept_start) begin
        dir <= DIR_LOAD;
      end else if (win_taken && !last_win) begin
        dir <= next_dir;
      end
      if (state == ST_PRO) begin
        rd_cnt <= '0;
      end else if (rd_taken) begin
        rd_cnt <= rd_cnt + 4'd1;
      end
    end
  end

  // Pixel coordinates of the current fetch. The position counter already
  // holds the new centre during the fetch, so moves read one pixel beyond it.
  always_comb begin
    load_off  = load_offset(rd_cnt);
    fetch_row = row;
    fetch_col = col;
    case (dir)
      DIR_LOAD: begin
        fetch_row = row - ONE + ADDR_W'(load_off[3:2]);
        fetch_col = col - ONE + ADDR_W'(load_off[1:0]);
      end
      DIR_RIGHT: begin
        fetch_row = row - ONE + ADDR_W'(rd_cnt[1:0]);
        fetch_col = col + ONE;
      end
      DIR_LEFT: begin
        fetch_row = row - ONE + ADDR_W'(rd_cnt[1:0]);
        fetch_col = col - ONE;
      end
      DIR_DOWN: begin
        fetch_row = row + ONE;
        fetch_col = col - ONE + ADDR_W'(rd_cnt[1:0]);
      end
      default: ;
    endcase
  end

  assign fetch_addr  = fetch_row * IMG_W_AW + fetch_col;
  assign center_addr = row * IMG_W_AW + col;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Bench for window_scan_ctrl: one 4x4 instance and one 3x5 instance share a
// clock and reset. Behavioural memory and window-buffer models answer the
// controller; expected read addresses and shift directions are queued from a
// table of per-window records and popped as the DUT produces them.
module tb_window_scan_ctrl;
  import sobel_pkg::*;

  localparam int AW = 16;

  typedef struct packed {
    logic [1:0]          dir;
    logic [3:0]          nrd;
    logic [8:0][AW-1:0]  addr;
    logic [AW-1:0]       center;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  logic [1:0]         start;
  logic [1:0]         busy;
  logic [1:0]         done;
  logic [1:0]         req;
  logic [1:0][AW-1:0] addr;
  logic [1:0]         mvalid;
  logic [1:0]         sshift;
  logic [1:0]         sread;
  logic [1:0][1:0]    direc;
  logic [1:0]         sdone;
  logic [1:0]         wvalid;
  logic [1:0]         wack;
  logic [1:0][AW-1:0] wctr;
  logic [1:0]         spur_v;

  logic [AW-1:0] addr_q[$];
  logic [1:0]    dir_q[$];
  int            checks;
  int            errors;
  int            rd_pulses[2];
  bit            rand_lat;
  bit            slow_shift;
  vec_t          tbl[7];

  window_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(AW)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .mem_rd_req(req[0]), .mem_rd_addr(addr[0]), .mem_rd_valid(mvalid[0]),
    .wb_start_shift(sshift[0]), .wb_start_read(sread[0]), .wb_shift_direc(direc[0]),
    .wb_shift_done(sdone[0]), .win_valid(wvalid[0]), .win_ack(wack[0]), .win_center(wctr[0])
  );

  window_scan_ctrl #(.IMG_W(3), .IMG_H(5), .ADDR_W(AW)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .mem_rd_req(req[1]), .mem_rd_addr(addr[1]), .mem_rd_valid(mvalid[1]),
    .wb_start_shift(sshift[1]), .wb_start_read(sread[1]), .wb_shift_direc(direc[1]),
    .wb_shift_done(sdone[1]), .win_valid(wvalid[1]), .win_ack(wack[1]), .win_center(wctr[1])
  );

  // Per-instance memory and window-buffer models, driven on the falling edge.
  for (genvar g = 0; g < 2; g++) begin : g_env
    logic          pend;
    logic          mv;
    logic          sd;
    int            cnt;
    int            sd_cnt;
    logic [1:0]    last_dir;
    logic [AW-1:0] exp_a;
    logic [1:0]    exp_d;

    assign mvalid[g] = mv | spur_v[g];
    assign sdone[g]  = sd;

    // Memory: capture a request, answer after 1..4 cycles, then accept the
    // next request on the cycle after the answer.
    always @(negedge clk or negedge n_rst) begin
      if (!n_rst) begin
        pend <= 1'b0;
        mv   <= 1'b0;
        cnt  <= 0;
      end else begin
        mv <= 1'b0;
        if (pend) begin
          if (cnt == 0) begin
            mv   <= 1'b1;
            pend <= 1'b0;
          end else begin
            cnt <= cnt - 1;
          end
        end else if (req[g]) begin
          pend <= 1'b1;
          cnt  <= rand_lat ? int'($urandom_range(3, 0)) : 0;
          checks++;
          if (addr_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL rd_addr dut%0d: got read of %0d, expected no read", g, addr[g]);
          end else begin
            exp_a = addr_q.pop_front();
            if (addr[g] !== exp_a) begin
              errors++;
              $display("[TB] FAIL rd_addr dut%0d: got %0d, expected %0d", g, addr[g], exp_a);
            end
          end
          checks++;
          if (direc[g] !== last_dir) begin
            errors++;
            $display("[TB] FAIL direc_hold dut%0d: got %0d, expected %0d", g, direc[g], last_dir);
          end
        end
      end
    end

    // Window buffer: check each shift command, acknowledge it a little later.
    always @(negedge clk or negedge n_rst) begin
      if (!n_rst) begin
        sd       <= 1'b0;
        sd_cnt   <= 0;
        last_dir <= 2'b00;
      end else begin
        sd <= 1'b0;
        if (sshift[g]) begin
          last_dir <= direc[g];
          sd_cnt   <= slow_shift ? 4 : int'($urandom_range(3, 1));
          checks++;
          if (dir_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL shift_dir dut%0d: got shift %0d, expected no shift", g, direc[g]);
          end else begin
            exp_d = dir_q.pop_front();
            if (direc[g] !== exp_d) begin
              errors++;
              $display("[TB] FAIL shift_dir dut%0d: got %0d, expected %0d", g, direc[g], exp_d);
            end
          end
        end else if (sd_cnt != 0) begin
          sd_cnt <= sd_cnt - 1;
          if (sd_cnt == 1) sd <= 1'b1;
        end
      end
    end

    // Buffer write strobes, sampled mid-cycle while mem_rd_valid is stable.
    always begin
      @(negedge clk);
      #3;
      if (n_rst && sread[g]) begin
        rd_pulses[g]++;
        checks++;
        if (mvalid[g] !== 1'b1) begin
          errors++;
          $display("[TB] FAIL rd_strobe dut%0d: got wb_start_read without valid (valid=%0d), expected 1", g, mvalid[g]);
        end
      end
    end
  end

  function automatic vec_t mkVec(input logic [1:0] d, input int n,
                                 input int a0, input int a1, input int a2,
                                 input int a3, input int a4, input int a5,
                                 input int a6, input int a7, input int a8,
                                 input int c);
    vec_t v;
    v.dir     = d;
    v.nrd     = 4'(n);
    v.addr[0] = AW'(a0); v.addr[1] = AW'(a1); v.addr[2] = AW'(a2);
    v.addr[3] = AW'(a3); v.addr[4] = AW'(a4); v.addr[5] = AW'(a5);
    v.addr[6] = AW'(a6); v.addr[7] = AW'(a7); v.addr[8] = AW'(a8);
    v.center  = AW'(c);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input int g, input string tag);
    checkOutput({tag, "_busy"},   busy[g],   0);
    checkOutput({tag, "_done"},   done[g],   0);
    checkOutput({tag, "_req"},    req[g],    0);
    checkOutput({tag, "_addr"},   addr[g],   0);
    checkOutput({tag, "_shift"},  sshift[g], 0);
    checkOutput({tag, "_read"},   sread[g],  0);
    checkOutput({tag, "_direc"},  direc[g],  0);
    checkOutput({tag, "_wvalid"}, wvalid[g], 0);
    checkOutput({tag, "_center"}, wctr[g],   0);
  endtask

  task automatic pushFrame(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      dir_q.push_back(tbl[i].dir);
      for (int j = 0; j < int'(tbl[i].nrd); j++) addr_q.push_back(tbl[i].addr[j]);
    end
  endtask

  // Run one frame on instance g from table rows first..last. With extras set,
  // also injects spurious inputs in SHIFT_WAIT, holds one window for 20
  // cycles with a start pulse inside, and raises start together with done.
  task automatic applyStimulus(input int g, input int first, input int last, input bit extras);
    int base_rd;
    int exp_rd;
    int budget;
    int hold_bad;
    base_rd = rd_pulses[g];
    exp_rd  = 0;
    for (int i = first; i <= last; i++) exp_rd += int'(tbl[i].nrd);
    pushFrame(first, last);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    checkOutput("busy_after_start", busy[g], 1);
    for (int i = first; i <= last; i++) begin
      budget = 0;
      while (wvalid[g] !== 1'b1 && budget < 200) begin
        @(negedge clk);
        budget++;
      end
      checkOutput("win_valid_seen", wvalid[g], 1);
      checkOutput("win_center", wctr[g], int'(tbl[i].center));
      if (extras && i == first + 1) begin
        hold_bad = 0;
        start[g] = 1'b1;
        for (int k = 0; k < 20; k++) begin
          if (wvalid[g] !== 1'b1 || wctr[g] !== tbl[i].center || req[g] !== 1'b0) hold_bad++;
          @(negedge clk);
          start[g] = 1'b0;
        end
        checkOutput("hold_stable_cycles_bad", hold_bad, 0);
      end
      wack[g] = 1'b1;
      @(negedge clk);
      wack[g] = 1'b0;
      if (extras && i == first) begin
        budget = 0;
        while (sshift[g] !== 1'b1 && budget < 10) begin
          @(negedge clk);
          budget++;
        end
        checkOutput("shift_after_ack", sshift[g], 1);
        @(negedge clk);
        hold_bad   = rd_pulses[g];
        spur_v[g]  = 1'b1;
        wack[g]    = 1'b1;
        @(negedge clk);
        spur_v[g]  = 1'b0;
        wack[g]    = 1'b0;
        checkOutput("spur_shiftwait_req", req[g], 0);
        checkOutput("spur_shiftwait_busy", busy[g], 1);
        checkOutput("spur_shiftwait_reads", rd_pulses[g] - hold_bad, 0);
      end
    end
    budget = 0;
    while (done[g] !== 1'b1 && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("done_pulse", done[g], 1);
    checkOutput("busy_at_done", busy[g], 0);
    if (extras) start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
    checkOutput("done_one_cycle", done[g], 0);
    if (extras) begin
      repeat (3) @(negedge clk);
      checkOutput("start_with_done_ignored", busy[g], 0);
      checkOutput("start_with_done_no_req", req[g], 0);
    end
    checkOutput("reads_total", rd_pulses[g] - base_rd, exp_rd);
    checkOutput("addr_q_left", addr_q.size(), 0);
    checkOutput("dir_q_left", dir_q.size(), 0);
  endtask

  initial begin
    int budget;
    int base_rd;
    checks     = 0;
    errors     = 0;
    rand_lat   = 1'b0;
    slow_shift = 1'b0;
    start      = '0;
    wack       = '0;
    spur_v     = '0;
    rd_pulses[0] = 0;
    rd_pulses[1] = 0;

    tbl[0] = mkVec(2'b00, 9, 0, 1, 2, 4, 5, 6, 8, 9, 10, 5);
    tbl[1] = mkVec(2'b01, 3, 3, 7, 11, 0, 0, 0, 0, 0, 0, 6);
    tbl[2] = mkVec(2'b11, 3, 13, 14, 15, 0, 0, 0, 0, 0, 0, 10);
    tbl[3] = mkVec(2'b10, 3, 4, 8, 12, 0, 0, 0, 0, 0, 0, 9);
    tbl[4] = mkVec(2'b00, 9, 0, 1, 2, 3, 4, 5, 6, 7, 8, 4);
    tbl[5] = mkVec(2'b11, 3, 9, 10, 11, 0, 0, 0, 0, 0, 0, 7);
    tbl[6] = mkVec(2'b11, 3, 12, 13, 14, 0, 0, 0, 0, 0, 0, 10);

    n_rst = 1'b1;
    #2 n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checkIdleOutputs(0, "reset_a");
    checkIdleOutputs(1, "reset_b");
    n_rst = 1'b1;
    @(negedge clk);

    // Spurious valid/ack while idle must not wake the sequencer.
    spur_v[0] = 1'b1;
    wack[0]   = 1'b1;
    @(negedge clk);
    spur_v[0] = 1'b0;
    wack[0]   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_spur_busy", busy[0], 0);
    checkOutput("idle_spur_req", req[0], 0);
    checkOutput("idle_spur_reads", rd_pulses[0], 0);

    $display("[TB] 4x4 frame, latency 1, corner cases");
    slow_shift = 1'b1;
    applyStimulus(0, 0, 3, 1'b1);
    slow_shift = 1'b0;

    $display("[TB] 4x4 frame aborted by reset after fifth read");
    rand_lat = 1'b1;
    base_rd  = rd_pulses[0];
    pushFrame(0, 3);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    budget = 0;
    while ((rd_pulses[0] - base_rd) < 5 && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("fifth_read_reached", int'((rd_pulses[0] - base_rd) >= 5), 1);
    #1 n_rst = 1'b0;
    #1;
    checkIdleOutputs(0, "abort");
    addr_q.delete();
    dir_q.delete();
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);

    $display("[TB] 4x4 frame restart, random latency");
    applyStimulus(0, 0, 3, 1'b0);

    $display("[TB] 3x5 frame, random latency");
    applyStimulus(1, 4, 6, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
